pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage pipeline register for the processor (F/D, D/X, X/M, M/W).
//   Carries PC, IR and two operands with a valid/ready handshake, and supports flush (bubble injection).
//   SKID=1 adds a second entry so that upstream ready is a registered signal and does not
//   combinationally depend on downstream stall.
//   Replaces the fixed-width, enable-only stage latches.
// PARAMETERS
//   PC_W    32  width of the PC field
//   IR_W    32  width of the instruction field
//   OP_W    32  width of each operand field (A, B)
//   NOP_IR  0   IR value presented whenever out_valid=0
//   SKID    1   1 = two-entry skid buffer; 0 = single entry with combinational in_ready
// PORTS
//   clk         in   1     rising-edge clock; single clock domain
//   reset       in   1     asynchronous, active-high; clears all state
//   flush       in   1     synchronous kill of all held and incoming beats
//   in_valid    in   1     upstream beat present
//   in_ready    out  1     stage accepts a beat this cycle
//   in_PC       in   PC_W  upstream PC
//   in_IR       in   IR_W  upstream instruction
//   data_in_A   in   OP_W  upstream operand A
//   data_in_B   in   OP_W  upstream operand B
//   out_valid   out  1     held beat present downstream
//   out_ready   in   1     downstream accepts the beat (low = stall)
//   out_PC      out  PC_W  head PC
//   out_IR      out  IR_W  head IR; NOP_IR when out_valid=0
//   data_out_A  out  OP_W  head operand A
//   data_out_B  out  OP_W  head operand B
// BEHAVIOUR
//   - Reset (async): main and skid valid=0; all fields=0.
//     During reset: out_valid=0, out_IR=NOP_IR, other outputs=0, in_ready=1.
//   - A beat is accepted when in_valid & in_ready. It is delivered when out_valid & out_ready.
//   - Latency: an accepted beat appears on the outputs the next cycle.
//     Throughput: 1 beat per cycle while out_ready=1.
//   - Packing: each field occupies its own slice of the packed word with no overlap.
//     Operand A lies entirely above operand B. Per-field round trip must be bit-exact.
//   - SKID=1 has states EMPTY, ONE (main only) and FULL (main + skid).
//       EMPTY: accept -> ONE.
//       ONE: accept without deliver -> FULL (beat goes into skid).
//            Accept with deliver -> ONE (main reloads).
//            Deliver only -> EMPTY.
//       FULL: in_ready=0. Deliver -> ONE (skid moves to main).
//     in_ready = ~skid_valid, registered; it never depends on out_ready in the same cycle.
//     Order is strictly FIFO; no beat is duplicated or dropped except by flush.
//   - SKID=0 has a single entry. in_ready = out_ready | ~out_valid (combinational).
//     A simultaneous deliver and accept replaces the entry in the same edge.
//   - A held beat keeps all outputs stable while out_valid=1 & out_ready=0.
//   - flush=1 at an edge:
//       both valids are cleared; field registers may keep stale data; outputs show NOP_IR.
//       Any beat presented that cycle is discarded. in_ready keeps its normal value.
//       Flush takes priority over accept and deliver. out_valid=0 on the following cycle.
//   - Reset asserted mid-stream discards all beats immediately, without waiting for a clock.
// STRUCTURE
//   - Shared package/header: default field widths and the NOP_IR encoding
//     (shared with decode and hazard logic).
//   - Sub-module pipe_slot: one data register of parametric width with an enable,
//     a valid flag and async reset. Instantiated once (SKID=0) or twice (SKID=1).
//   - Top level: occupancy state, muxing of load-from-input versus load-from-skid,
//     and output gating to NOP_IR.
// TESTING
//   1. Reset held for 3 cycles with in_valid=1 -> out_valid=0, out_IR=NOP_IR, in_ready=1;
//      no beat is captured.
//   2. Stream of PC=0x10,0x14,0x18 with A=0xAAAA0000 and B=0x0000BBBB, out_ready=1 ->
//      each beat out 1 cycle later with exact fields; A and B are not swapped or truncated.
//   3. SKID=1: accept beats P1 and P2, then out_ready=0 ->
//      the cycle after P2 is accepted, in_ready=0 and out_PC holds P1.
//      Raise out_ready -> P1 then P2 delivered in order; in_ready returns to 1.
//   4. SKID=0: out_ready=0 with a beat held -> in_ready=0 in the same cycle.
//      Deliver and accept together -> new beat on the outputs the next cycle.
//   5. flush in FULL state with in_valid=1 (PC=0x40) -> out_valid=0 and out_IR=NOP_IR
//      the next cycle; 0x40 is never delivered.
//   6. Assert reset asynchronously between edges while in ONE state ->
//      out_valid falls before the next edge; the bench clock and reset drive clk and reset.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-register defaults: field widths, NOP encoding, occupancy states.
package pipe_stage_reg_pkg;

    localparam int          PC_W_DEF   = 32;
    localparam int          IR_W_DEF   = 32;
    localparam int          OP_W_DEF   = 32;
    // Encoding decode/hazard logic treats as a bubble.
    localparam logic [31:0] NOP_IR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One data register with load enable plus a valid flag, both cleared by async reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_d_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Valid follows the next-state every cycle; data only moves when loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d_i;
            if (load_i) data_q <= data_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush and optional skid entry.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              IR_W   = IR_W_DEF,
    parameter int              OP_W   = OP_W_DEF,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF),
    parameter bit              SKID   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_PC,
    input  logic [IR_W-1:0] in_IR,
    input  logic [OP_W-1:0] data_in_A,
    input  logic [OP_W-1:0] data_in_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_PC,
    output logic [IR_W-1:0] out_IR,
    output logic [OP_W-1:0] data_out_A,
    output logic [OP_W-1:0] data_out_B
);

    // Packed word layout, MSB to LSB: PC | IR | A | B.
    localparam int W     = PC_W + IR_W + 2 * OP_W;
    localparam int B_LO  = 0;
    localparam int A_LO  = OP_W;
    localparam int IR_LO = 2 * OP_W;
    localparam int PC_LO = 2 * OP_W + IR_W;

    logic [W-1:0] in_word, main_word, skid_word, main_din;
    logic         main_v, skid_v, main_v_d, skid_v_d;
    logic         main_ld, main_from_skid, skid_ld;
    logic         acc, dlv;
    occ_e         occ;

    assign in_word = {in_PC, in_IR, data_in_A, data_in_B};
    assign acc     = in_valid & in_ready;
    assign dlv     = main_v & out_ready;

    // Occupancy is held in the slot valid flags; decode it to a named state.
    always_comb begin
        occ = OCC_EMPTY;
        if (main_v) occ = skid_v ? OCC_FULL : OCC_ONE;
    end

    // Next occupancy and slot load controls; flush overrides accept and deliver.
    always_comb begin
        main_v_d       = main_v;
        skid_v_d       = skid_v;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: if (acc) begin
                    main_ld  = 1'b1;
                    main_v_d = 1'b1;
                end
                OCC_ONE: begin
                    // With SKID=0 an accept always coincides with a deliver.
                    if (acc && dlv) begin
                        main_ld = 1'b1;
                    end else if (acc) begin
                        skid_ld  = 1'b1;
                        skid_v_d = 1'b1;
                    end else if (dlv) begin
                        main_v_d = 1'b0;
                    end
                end
                OCC_FULL: if (dlv) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_v_d       = 1'b0;
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    assign main_din = main_from_skid ? skid_word : in_word;

    pipe_slot #(.W(W)) u_main (
        .clk      (clk),
        .reset    (reset),
        .load_i   (main_ld),
        .data_i   (main_din),
        .valid_d_i(main_v_d),
        .data_o   (main_word),
        .valid_o  (main_v)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.W(W)) u_skid (
                .clk      (clk),
                .reset    (reset),
                .load_i   (skid_ld),
                .data_i   (in_word),
                .valid_d_i(skid_v_d),
                .data_o   (skid_word),
                .valid_o  (skid_v)
            );
        end else begin : g_noskid
            logic unused_skid;
            assign skid_word   = '0;
            assign skid_v      = 1'b0;
            assign unused_skid = skid_ld ^ skid_v_d;
        end
    endgenerate

    // Upstream ready and head-of-queue outputs, IR gated to NOP when empty.
    always_comb begin
        in_ready   = SKID ? ~skid_v : (out_ready | ~main_v);
        out_valid  = main_v;
        out_PC     = main_word[PC_LO +: PC_W];
        out_IR     = main_v ? main_word[IR_LO +: IR_W] : NOP_IR;
        data_out_A = main_word[A_LO +: OP_W];
        data_out_B = main_word[B_LO +: OP_W];
    end

endmodule
